// File: rtl/flop_en_rst_clr.sv
// Generic pipeline storage register: synchronous active-low reset, synchronous
// clear (bubble/flush) and load enable (stall), priority rst > clr > en > hold.
module flop_en_rst_clr #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;

    if (WIDTH < 1) begin : g_bad_width
        $error("flop_en_rst_clr: WIDTH must be at least 1");
    end

    // A flush must win over a stall release, so clr is tested before en.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = CLEAR_VAL;
        end else if (en) begin
            state_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst !== 1'b0 && $isunknown({rst, clr, en})) begin
            $warning("flop_en_rst_clr: unknown control rst=%b clr=%b en=%b", rst, clr, en);
        end
    end
`endif

endmodule

// File: tb/tb_flop_en_rst_clr.sv
// Self-checking bench for flop_en_rst_clr: directed priority/latency/width cases
// followed by randomized traffic against a behavioural reference model.
module tb_flop_en_rst_clr;

    logic         clk;
    logic         rst;
    logic         en;
    logic         clr;
    logic [7:0]   d8;
    logic [0:0]   d1;
    logic [199:0] d200;
    logic [7:0]   q_a;
    logic [7:0]   q_b;
    logic [0:0]   q_c;
    logic [199:0] q_d;

    int checks;
    int failures;

    // Reference model state, one per instance, plus a "has been reset" flag.
    logic [199:0] m_a, m_b, m_c, m_d;
    bit           known;

    localparam logic [199:0] D_CLR = {25{8'hC3}};

    flop_en_rst_clr #(.WIDTH(8), .RESET_VAL(8'hA5), .CLEAR_VAL(8'h5A)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d8), .q(q_a));

    flop_en_rst_clr #(.WIDTH(8), .RESET_VAL(8'h00), .CLEAR_VAL(8'h5A)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d8), .q(q_b));

    flop_en_rst_clr #(.WIDTH(1), .RESET_VAL(1'b0), .CLEAR_VAL(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d1), .q(q_c));

    flop_en_rst_clr #(.WIDTH(200), .RESET_VAL('1), .CLEAR_VAL(D_CLR)) u_d (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .d(d200), .q(q_d));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [199:0] obs, input logic [199:0] expv);
        checks++;
        if (obs !== expv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Result selected from a table of candidate sources indexed by which rule fires.
    function automatic logic [199:0] model_next(input logic [199:0] prev, input logic [199:0] rv,
                                                input logic [199:0] cv, input logic [199:0] dv,
                                                input logic r, input logic c, input logic e);
        logic [199:0] cand [4];
        int           sel;
        cand[0] = rv;
        cand[1] = cv;
        cand[2] = dv;
        cand[3] = prev;
        sel = (r == 1'b0) ? 0 : (c ? 1 : (e ? 2 : 3));
        return cand[sel];
    endfunction

    task automatic step(input string tag, input logic r, input logic c, input logic e,
                        input logic [7:0] dv);
        rst  = r;
        clr  = c;
        en   = e;
        d8   = dv;
        d1   = dv[0];
        d200 = {dv, $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        @(posedge clk);
        m_a = model_next(m_a, 200'hA5, 200'h5A, {192'd0, d8}, r, c, e);
        m_b = model_next(m_b, 200'h00, 200'h5A, {192'd0, d8}, r, c, e);
        m_c = model_next(m_c, 200'h0,  200'h1,  {199'd0, d1}, r, c, e);
        m_d = model_next(m_d, {200{1'b1}}, D_CLR, d200, r, c, e);
        if (!r) known = 1'b1;
        #1;
        if (known) begin
            chk_val({tag, "_w8a"},   {192'd0, q_a}, m_a);
            chk_val({tag, "_w8b"},   {192'd0, q_b}, m_b);
            chk_val({tag, "_w1"},    {199'd0, q_c}, m_c);
            chk_val({tag, "_w200"},  q_d, m_d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        known    = 1'b0;
        m_a = '0; m_b = '0; m_c = '0; m_d = '0;
        rst = 1'b1; clr = 1'b0; en = 1'b0; d8 = '0; d1 = '0; d200 = '0;
        @(negedge clk);

        // Reset overrides clear and enable on the same edge.
        step("reset", 1'b0, 1'b1, 1'b1, 8'h3C);
        chk_val("reset_a5", {192'd0, q_a}, 200'hA5);
        chk_val("reset_beats_clear", {192'd0, q_b}, 200'h00);
        chk_val("reset_w200_ones", q_d, {200{1'b1}});
        step("load", 1'b1, 1'b0, 1'b1, 8'h3C);
        chk_val("load_3c", {192'd0, q_a}, 200'h3C);

        // Enable low holds despite changing d.
        step("load11", 1'b1, 1'b0, 1'b1, 8'h11);
        for (int i = 0; i < 3; i++) begin
            step("hold", 1'b1, 1'b0, 1'b0, 8'hFF);
            chk_val("hold_11", {192'd0, q_a}, 200'h11);
        end
        step("release", 1'b1, 1'b0, 1'b1, 8'hFF);
        chk_val("release_ff", {192'd0, q_a}, 200'hFF);

        // Clear wins with or without enable.
        step("load11b", 1'b1, 1'b0, 1'b1, 8'h11);
        step("clr_en", 1'b1, 1'b1, 1'b1, 8'h77);
        chk_val("clr_en_5a", {192'd0, q_a}, 200'h5A);
        step("load11c", 1'b1, 1'b0, 1'b1, 8'h11);
        step("clr_noen", 1'b1, 1'b1, 1'b0, 8'h77);
        chk_val("clr_noen_5a", {192'd0, q_a}, 200'h5A);
        chk_val("clr_w1", {199'd0, q_c}, 200'h1);

        step("rst_clr", 1'b0, 1'b1, 1'b0, 8'h77);
        chk_val("rst_clr_b00", {192'd0, q_b}, 200'h00);

        // Back-to-back stream: each value visible one edge after capture.
        for (int i = 1; i <= 4; i++) begin
            step("stream", 1'b1, 1'b0, 1'b1, 8'(i));
            chk_val("stream_q", {192'd0, q_a}, 200'(i));
            chk_val("stream_w1", {199'd0, q_c}, 200'(i % 2));
        end

        // Randomized traffic with occasional resets and frequent stalls/flushes.
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(0, 15) != 0), ($urandom_range(0, 3) == 0),
                 $urandom_range(0, 1) == 1, 8'($urandom()));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
